multi_sender: RTL

MULTI_SENDER -- requirements
Module: multi_sender

---
 rtl/multi_sender_pkg.sv | 19 +
 rtl/multi_sender_if.sv | 30 +++
 rtl/multi_sender_digit_fifo.sv | 57 +++++
 rtl/multi_sender.sv | 125 ++++++++++++
 4 files changed

// File: rtl/multi_sender_pkg.sv
// Shared types for the multi_sender digit transmitter: FSM state encoding
// and the chunk-count helper used to split a digit across the output lanes.
package multi_sender_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STROBE,
    GAP,
    FINISH,
    RELEASE
  } state_t;

  // Number of LANES-wide chunks needed to carry one digit.
  function automatic int chunks(input int digit_w, input int lanes);
    return (digit_w + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/multi_sender_if.sv
// Push-side handshake plus the strobed lane outputs of multi_sender.
// The slave modport is the transmitter's view; master is the driver's view.
interface multi_sender_if #(
  parameter int DIGIT_W = 4,
  parameter int LANES   = 3,
  parameter int DEPTH   = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               push_valid;
  logic [DIGIT_W-1:0] push_digit;
  logic               push_ready;
  logic               enabled;
  logic [LANES-1:0]   out;
  logic               controlOut;
  logic               active;
  logic               done;
  logic [CNT_W-1:0]   count;

  modport master (
    output push_valid, push_digit, enabled,
    input  push_ready, out, controlOut, active, done, count
  );

  modport slave (
    input  push_valid, push_digit, enabled,
    output push_ready, out, controlOut, active, done, count
  );

endinterface

// File: rtl/multi_sender_digit_fifo.sv
// Circular digit FIFO with occupancy counter. Pushes while full are dropped;
// fullness is judged before any same-cycle pop.
module digit_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             hwclk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

  always_ff @(posedge hwclk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/multi_sender.sv
// Queues digits and, while enabled, sends each one as strobed LANES-wide
// chunks (LSB first) followed by a single done pulse per frame.
module multi_sender
  import multi_sender_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int LANES   = 3,
  parameter int DEPTH   = 8,
  parameter int HOLD    = 2
) (
  input logic           hwclk,
  input logic           rst,
  multi_sender_if.slave bus
);
  localparam int CHUNKS  = chunks(DIGIT_W, LANES);
  localparam int PAD_W   = CHUNKS * LANES;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int HOLD_W  = $clog2(HOLD) + 1;
  localparam int CHUNK_W = $clog2(CHUNKS) + 1;

  state_t             state_reg,  state_next;
  logic [HOLD_W-1:0]  timer_reg,  timer_next;
  logic [CHUNK_W-1:0] chunk_reg,  chunk_next;
  logic [PAD_W-1:0]   shift_reg,  shift_next;

  logic               pop;
  logic [DIGIT_W-1:0] head;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               phase_end;

  digit_fifo #(
    .W     (DIGIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .hwclk     (hwclk),
    .rst       (rst),
    .push      (bus.push_valid),
    .push_data (bus.push_digit),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      chunk_reg <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      chunk_reg <= chunk_next;
      shift_reg <= shift_next;
    end
  end

  assign phase_end = (timer_reg == HOLD_W'(HOLD - 1));

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    chunk_next = chunk_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.enabled) begin
          timer_next = '0;
          state_next = empty ? FINISH : LOAD;
        end
      end
      LOAD: begin
        pop        = 1'b1;
        shift_next = PAD_W'(head);
        chunk_next = '0;
        timer_next = '0;
        state_next = STROBE;
      end
      STROBE: begin
        if (phase_end) begin
          timer_next = '0;
          state_next = GAP;
        end else begin
          timer_next = timer_reg + HOLD_W'(1);
        end
      end
      GAP: begin
        if (phase_end) begin
          timer_next = '0;
          if (chunk_reg != CHUNK_W'(CHUNKS - 1)) begin
            chunk_next = chunk_reg + CHUNK_W'(1);
            shift_next = shift_reg >> LANES;
            state_next = STROBE;
          end else if (!empty) begin
            state_next = LOAD;
          end else begin
            state_next = FINISH;
          end
        end else begin
          timer_next = timer_reg + HOLD_W'(1);
        end
      end
      FINISH:  state_next = RELEASE;
      RELEASE: if (!bus.enabled) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Dropping enabled mid-frame discards the popped digit; the queue stays.
    if (!bus.enabled && (state_reg == LOAD || state_reg == STROBE || state_reg == GAP)) begin
      state_next = IDLE;
    end
  end

  assign bus.out        = (state_reg == STROBE || state_reg == GAP) ? shift_reg[LANES-1:0] : '0;
  assign bus.controlOut = (state_reg == STROBE);
  assign bus.active     = (state_reg == LOAD) || (state_reg == STROBE) || (state_reg == GAP);
  assign bus.done       = (state_reg == FINISH);
  assign bus.push_ready = !full;
  assign bus.count      = fifo_count;

endmodule
